// File: rtl/mod_hex_display.sv
// mod_hex_display: latches a hex value and drives active-low 7-segment digits
// with optional leading-zero blanking and whole-display blinking.
module mod_hex_display #(
    parameter int DIGITS = 4,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic                  i_load,
    input  logic                  i_blank_lz,
    input  logic                  i_blink,
    output logic [7*DIGITS-1:0]   o_segments,
    output logic [4*DIGITS-1:0]   o_value,
    output logic                  o_ack
);
    logic [4*DIGITS-1:0] r_value;
    logic [31:0]         blink_cnt;
    logic                phase;
    logic                on;
    logic                wrap;
    logic [DIGITS-1:0]   lz;
    logic [7*DIGITS-1:0] seg_next;

    // Returns lit segments with segment a in bit 0 through g in bit 6.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b1111110;
            4'h1: p = 7'b0110000;
            4'h2: p = 7'b1101101;
            4'h3: p = 7'b1111001;
            4'h4: p = 7'b0110011;
            4'h5: p = 7'b1011011;
            4'h6: p = 7'b1011111;
            4'h7: p = 7'b1110000;
            4'h8: p = 7'b1111111;
            4'h9: p = 7'b1111011;
            4'hA: p = 7'b1110111;
            4'hB: p = 7'b0011111;
            4'hC: p = 7'b1001110;
            4'hD: p = 7'b0111101;
            4'hE: p = 7'b1001111;
            default: p = 7'b1000111;
        endcase
        for (int i = 0; i < 7; i++) decode[i] = p[6-i];
    endfunction

    assign o_value = r_value;
    assign wrap    = blink_cnt == BLINK_DIV - 1;
    // A blink disable overrides the phase immediately, not one edge later.
    assign on      = phase | ~i_blink;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign lz[k] = (k != 0) && i_blank_lz && ((r_value >> (4*k)) == '0);
        assign seg_next[7*k +: 7] = (on && !lz[k]) ? ~decode(r_value[4*k +: 4]) : 7'h7F;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_value    <= '0;
            o_ack      <= 1'b0;
            blink_cnt  <= '0;
            phase      <= 1'b1;
            o_segments <= '1;
        end else begin
            o_ack      <= i_load;
            r_value    <= i_load ? i_value : r_value;
            blink_cnt  <= (!i_blink || wrap) ? '0 : blink_cnt + 32'd1;
            phase      <= !i_blink ? 1'b1 : (wrap ? ~phase : phase);
            o_segments <= seg_next;
        end
    end
endmodule
